// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } estado_t;

  localparam int SCAN_CYCLES_DEF     = 1000;
  localparam int DEBOUNCE_CYCLES_DEF = 100000;

  // Indexed by {row, col}; row 0 / col 0 are the MSBs of filas / col.
  localparam logic [3:0] MAPA [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic es_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Bit 3 maps to index 0, so the same decode serves rows and columns.
  function automatic logic [1:0] indice_onehot(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: row rotation, press/release debounce, one pulse per key.
module escaner_teclado
  import teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] filas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_presionada
);

  localparam int MAXC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SC_LAST  = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_PRESS = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_REL   = CW'(DEBOUNCE_CYCLES - 1);

  estado_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    col_s, col_q, col_q_n, filas_n, tecla_n, filas_rot;
  logic [1:0]    row_q, row_q_n;

  sincronizador_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col),
    .q   (col_s)
  );

  assign filas_rot = {filas[0], filas[3:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCAN;
      cnt   <= '0;
      filas <= 4'b1000;
      col_q <= 4'd0;
      row_q <= 2'd0;
      tecla <= 4'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      filas <= filas_n;
      col_q <= col_q_n;
      row_q <= row_q_n;
      tecla <= tecla_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    filas_n = filas;
    col_q_n = col_q;
    row_q_n = row_q;
    tecla_n = tecla;
    case (state)
      SCAN: begin
        if (cnt == SC_LAST) begin
          cnt_n = '0;
          if (es_onehot(col_s)) begin
            col_q_n = col_s;
            row_q_n = indice_onehot(filas);
            state_n = DEBOUNCE;
          end else begin
            filas_n = filas_rot;
          end
        end
      end
      DEBOUNCE: begin
        if (col_s != col_q) begin
          state_n = SCAN;
          filas_n = filas_rot;
          cnt_n   = '0;
        end else if (cnt == DB_PRESS) begin
          state_n = PRESSED;
          cnt_n   = '0;
          tecla_n = MAPA[{row_q, indice_onehot(col_q)}];
        end
      end
      PRESSED, RELEASE: begin
        // Any activity on the columns, even another key, restarts the release count.
        state_n = RELEASE;
        if (col_s != 4'd0) begin
          cnt_n = '0;
        end else if (cnt == DB_REL) begin
          state_n = SCAN;
          filas_n = filas_rot;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = SCAN;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    tecla_valida     = (state == PRESSED);
    tecla_presionada = (state == PRESSED) || (state == RELEASE);
  end

endmodule

// File: tb/tb_escaner_teclado.sv
// Scoreboard bench: keypad model drives col from filas, monitor checks each tecla_valida.
module tb_escaner_teclado;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col, filas, tecla;
  logic       tecla_valida, tecla_presionada;

  logic       fisico = 1'b0;
  logic       key_on = 1'b0;
  logic [1:0] key_r  = 2'd0;
  logic [1:0] key_c  = 2'd0;
  logic [3:0] col_dir = 4'd0;

  int total = 0, bad = 0, pulsos = 0, esperados = 0;
  logic [3:0] exp_q[$];

  logic [3:0] ref_map [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  always #5 clk = ~clk;

  // A physical key shorts its row line onto its column line.
  always_comb begin
    col = col_dir;
    if (fisico) col = (key_on && filas[2'd3 - key_r]) ? (4'b1000 >> key_c) : 4'b0000;
  end

  escaner_teclado #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .col              (col),
    .filas            (filas),
    .tecla            (tecla),
    .tecla_valida     (tecla_valida),
    .tecla_presionada (tecla_presionada)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_filas(input logic [3:0] v, input int lim, input string nm);
    int k;
    k = 0;
    while (filas !== v && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(filas), 32'(v));
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold, input bit larga);
    fisico = 1'b1;
    key_r  = r;
    key_c  = c;
    if (larga) begin
      exp_q.push_back(ref_map[r][c]);
      esperados++;
    end
    key_on = 1'b1;
    tick(hold);
    key_on = 1'b0;
    tick(20);
  endtask

  always @(negedge clk) begin
    if (!rst && tecla_valida) begin
      pulsos++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pulse_unexpected: got tecla=%0h expected no pulse", tecla);
      end else begin
        chk("pulse_tecla", 32'(tecla), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mask;
    bit larga;
    int k;

    rst = 1'b1;
    tick(3);
    chk("rst_filas", 32'(filas), 32'h8);
    chk("rst_tecla", 32'(tecla), 32'h0);
    chk("rst_valida", 32'(tecla_valida), 32'h0);
    chk("rst_presionada", 32'(tecla_presionada), 32'h0);

    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      chk("rotate", 32'(filas), 32'(4'b1000 >> ((n / 4) % 4)));
      tick(1);
    end

    // Held column on row 2, column 1 -> key 8.
    wait_filas(4'b0010, 16, "reach_row2");
    exp_q.push_back(4'h8);
    esperados++;
    col_dir = 4'b0100;
    tick(14);
    chk("held_presionada", 32'(tecla_presionada), 32'h1);
    chk("held_filas", 32'(filas), 32'h2);
    col_dir = 4'b0000;
    tick(4);
    chk("release_hold", 32'(filas), 32'h2);
    wait_filas(4'b0001, 10, "release_next");
    chk("release_presionada", 32'(tecla_presionada), 32'h0);
    chk("pulses_single", 32'(pulsos), 32'd1);

    // Bounce shorter than the debounce window.
    col_dir = 4'b1000;
    tick(2);
    col_dir = 4'b0000;
    tick(10);
    chk("bounce_tecla_kept", 32'(tecla), 32'h8);
    chk("bounce_presionada", 32'(tecla_presionada), 32'h0);
    chk("bounce_pulses", 32'(pulsos), 32'd1);

    // Two columns at once never count as a press.
    col_dir = 4'b0011;
    mask = 4'd0;
    repeat (20) begin
      tick(1);
      mask = mask | filas;
    end
    col_dir = 4'b0000;
    tick(4);
    chk("multi_rotate", 32'(mask), 32'hF);
    chk("multi_pulses", 32'(pulsos), 32'd1);

    press(2'd3, 2'd1, 40, 1'b1);
    press(2'd0, 2'd3, 40, 1'b1);
    chk("pair_pulses", 32'(pulsos), 32'd3);

    for (int i = 0; i < 10; i++) begin
      larga = ($urandom_range(0, 2) != 0);
      press(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            larga ? 40 : int'($urandom_range(1, 2)), larga);
    end
    tick(10);
    chk("random_pulses", 32'(pulsos), 32'(esperados));

    // Reset while a key is held.
    fisico = 1'b1;
    key_r  = 2'd1;
    key_c  = 2'd2;
    exp_q.push_back(4'h6);
    esperados++;
    key_on = 1'b1;
    k = 0;
    while (!tecla_presionada && k < 40) begin
      tick(1);
      k++;
    end
    chk("reach_pressed", 32'(tecla_presionada), 32'h1);
    tick(2);
    rst = 1'b1;
    #1;
    chk("rstmid_filas", 32'(filas), 32'h8);
    chk("rstmid_presionada", 32'(tecla_presionada), 32'h0);
    chk("rstmid_valida", 32'(tecla_valida), 32'h0);
    chk("rstmid_tecla", 32'(tecla), 32'h0);
    tick(3);
    key_on = 1'b0;
    rst = 1'b0;
    tick(30);
    chk("final_pulses", 32'(pulsos), 32'(esperados));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
